acc_predecoder_stream: RTL and testbench

// Registered, multi-channel successor of the combinational offload predecoder. Sits between the

---
 rtl/acc_predecoder_stream.sv | 201 ++++++++++++++++++++
 tb/tb_acc_predecoder_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_predecoder_stream.sv
// acc_predecoder_stream: registered multi-channel offload predecoder.
// Matches each accepted instruction word against per-channel mask/match
// tables, reports the winning channel and its decode fields one cycle later
// behind a valid/ready output stage, and keeps saturating accept/reject counts.

package acc_pkg;

   typedef enum logic [1:0] {
      OP_RS   = 2'd0,
      OP_IMM  = 2'd1,
      OP_PC   = 2'd2,
      OP_ZERO = 2'd3
   } op_sel_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef struct packed {
      logic       accept;
      logic       writeback;
      logic [2:0] use_rs;
      op_sel_e    op_a_mux;
      op_sel_e    op_b_mux;
      imm_sel_e   imm_a_mux;
      imm_sel_e   imm_b_mux;
   } prd_rsp_t;

   localparam prd_rsp_t PrdRspDefault = '{
      accept:    1'b0,
      writeback: 1'b0,
      use_rs:    3'b000,
      op_a_mux:  OP_RS,
      op_b_mux:  OP_RS,
      imm_a_mux: IMM_I,
      imm_b_mux: IMM_I
   };

   typedef struct packed {
      logic [31:0] instr_data;
      logic [31:0] instr_mask;
      prd_rsp_t    prd_rsp;
   } offl_instr_t;

endpackage

module acc_predecoder_stream #(
   parameter int unsigned          NumChannels = 2,
   parameter int unsigned          NumInstr    = 4,
   parameter acc_pkg::offl_instr_t OfflInstr [NumChannels][NumInstr] = '{default: '0},
   parameter int unsigned          CntWidth    = 16,
   localparam int unsigned         ChW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic [NumChannels-1:0] ch_en_i,
   input  logic [31:0]            q_instr_data_i,
   input  logic                   q_valid_i,
   output logic                   q_ready_o,
   output logic                   p_valid_o,
   input  logic                   p_ready_i,
   output logic                   p_accept_o,
   output logic [ChW-1:0]         p_chan_o,
   output acc_pkg::prd_rsp_t      p_rsp_o,
   output logic [31:0]            p_instr_o,
   output logic                   p_multi_o,
   output logic [CntWidth-1:0]    accept_cnt_o,
   output logic [CntWidth-1:0]    reject_cnt_o
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic [NumChannels-1:0] ChOne = NumChannels'(1);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e                 r_state_p1;
   state_e                 w_state_next;

   logic [NumChannels-1:0] w_ch_hit_p0;
   logic                   w_found_p0;
   logic [ChW-1:0]         w_win_ch_p0;
   acc_pkg::prd_rsp_t      w_win_rsp_p0;
   logic                   w_multi_p0;
   logic                   w_hs;
   logic                   w_load;

   logic                   r_accept_p1;
   logic [ChW-1:0]         r_chan_p1;
   acc_pkg::prd_rsp_t      r_rsp_p1;
   logic [31:0]            r_instr_p1;
   logic                   r_multi_p1;
   logic [CntWidth-1:0]    r_accept_cnt;
   logic [CntWidth-1:0]    r_reject_cnt;

   // ---- stage p0: table match on the incoming word ----

   // Scan all entries; remember per-channel hits and the first hit in (channel, index) order.
   always_comb begin
      w_ch_hit_p0  = '0;
      w_found_p0   = 1'b0;
      w_win_ch_p0  = '0;
      w_win_rsp_p0 = acc_pkg::PrdRspDefault;
      for (int c = 0; c < int'(NumChannels); c++) begin
         for (int i = 0; i < int'(NumInstr); i++) begin
            if (ch_en_i[c] &&
                ((OfflInstr[c][i].instr_mask & q_instr_data_i) == OfflInstr[c][i].instr_data)) begin
               w_ch_hit_p0[c] = 1'b1;
               if (!w_found_p0) begin
                  w_found_p0          = 1'b1;
                  w_win_ch_p0         = ChW'(c);
                  w_win_rsp_p0        = OfflInstr[c][i].prd_rsp;
                  w_win_rsp_p0.accept = 1'b1;
               end
            end
         end
      end
   end

   // More than one channel bit set means hits in at least two distinct channels.
   assign w_multi_p0 = |(w_ch_hit_p0 & (w_ch_hit_p0 - ChOne));

   assign q_ready_o  = (r_state_p1 == EMPTY) || p_ready_i;
   assign w_hs       = q_valid_i && q_ready_o;
   // A handshake coinciding with flush is dropped entirely: not stored, not counted.
   assign w_load     = w_hs && !flush_i;

   // ---- stage p1: output register and handshake FSM ----

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state_p1 <= EMPTY;
      end else begin
         r_state_p1 <= w_state_next;
      end
   end

   // Next-state: fill on handshake, drain when consumed without a refill, flush always empties.
   always_comb begin
      w_state_next = r_state_p1;
      if (flush_i) begin
         w_state_next = EMPTY;
      end else begin
         case (r_state_p1)
            EMPTY:   if (w_hs) w_state_next = FULL;
            FULL:    if (p_ready_i && !w_hs) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
         endcase
      end
   end

   // Result payload; held while stalled, left untouched by flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_accept_p1 <= 1'b0;
         r_chan_p1   <= '0;
         r_rsp_p1    <= acc_pkg::PrdRspDefault;
         r_instr_p1  <= '0;
         r_multi_p1  <= 1'b0;
      end else if (w_load) begin
         r_accept_p1 <= w_found_p0;
         r_chan_p1   <= w_win_ch_p0;
         r_rsp_p1    <= w_win_rsp_p0;
         r_instr_p1  <= q_instr_data_i;
         r_multi_p1  <= w_multi_p0;
      end
   end

   // Saturating statistics, one increment per counted handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_accept_cnt <= '0;
         r_reject_cnt <= '0;
      end else if (w_load) begin
         if (w_found_p0) r_accept_cnt <= sat_inc(r_accept_cnt);
         else            r_reject_cnt <= sat_inc(r_reject_cnt);
      end
   end

   assign p_valid_o    = (r_state_p1 == FULL);
   assign p_accept_o   = r_accept_p1;
   assign p_chan_o     = r_chan_p1;
   assign p_rsp_o      = r_rsp_p1;
   assign p_instr_o    = r_instr_p1;
   assign p_multi_o    = r_multi_p1;
   assign accept_cnt_o = r_accept_cnt;
   assign reject_cnt_o = r_reject_cnt;

endmodule

// File: tb/tb_acc_predecoder_stream.sv
// Directed bench for acc_predecoder_stream with a 2x4 table and 4-bit counters.

module tb_acc_predecoder_stream;

   localparam acc_pkg::prd_rsp_t RSP0 = '{accept: 1'b0, writeback: 1'b1, use_rs: 3'b011,
      op_a_mux: acc_pkg::OP_RS, op_b_mux: acc_pkg::OP_IMM,
      imm_a_mux: acc_pkg::IMM_I, imm_b_mux: acc_pkg::IMM_S};
   localparam acc_pkg::prd_rsp_t RSPX = '{accept: 1'b0, writeback: 1'b0, use_rs: 3'b111,
      op_a_mux: acc_pkg::OP_PC, op_b_mux: acc_pkg::OP_ZERO,
      imm_a_mux: acc_pkg::IMM_J, imm_b_mux: acc_pkg::IMM_U};
   localparam acc_pkg::prd_rsp_t RSP1 = '{accept: 1'b0, writeback: 1'b0, use_rs: 3'b001,
      op_a_mux: acc_pkg::OP_IMM, op_b_mux: acc_pkg::OP_RS,
      imm_a_mux: acc_pkg::IMM_U, imm_b_mux: acc_pkg::IMM_B};
   localparam acc_pkg::prd_rsp_t RSP2 = '{accept: 1'b0, writeback: 1'b1, use_rs: 3'b100,
      op_a_mux: acc_pkg::OP_ZERO, op_b_mux: acc_pkg::OP_PC,
      imm_a_mux: acc_pkg::IMM_B, imm_b_mux: acc_pkg::IMM_J};

   localparam acc_pkg::offl_instr_t FILL = '{instr_data: 32'hFFFF_FFFF,
      instr_mask: 32'hFFFF_FFFF, prd_rsp: acc_pkg::PrdRspDefault};

   localparam acc_pkg::offl_instr_t TBL [2][4] = '{
      '{ '{instr_data: 32'h0000_002B, instr_mask: 32'h0000_007F, prd_rsp: RSP0},
         '{instr_data: 32'h0000_002B, instr_mask: 32'hFFFF_FFFF, prd_rsp: RSPX},
         FILL, FILL },
      '{ '{instr_data: 32'h0000_002B, instr_mask: 32'h0000_707F, prd_rsp: RSP1},
         '{instr_data: 32'h0000_005B, instr_mask: 32'h0000_007F, prd_rsp: RSP2},
         FILL, FILL }
   };

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [1:0]        ch_en;
   logic [31:0]       q_data;
   logic              q_valid;
   logic              q_ready;
   logic              p_valid;
   logic              p_ready;
   logic              p_accept;
   logic [0:0]        p_chan;
   acc_pkg::prd_rsp_t p_rsp;
   logic [31:0]       p_instr;
   logic              p_multi;
   logic [3:0]        acc_cnt;
   logic [3:0]        rej_cnt;

   int n_chk;
   int n_pass;

   acc_predecoder_stream #(
      .NumChannels (2),
      .NumInstr    (4),
      .OfflInstr   (TBL),
      .CntWidth    (4)
   ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (flush),
      .ch_en_i        (ch_en),
      .q_instr_data_i (q_data),
      .q_valid_i      (q_valid),
      .q_ready_o      (q_ready),
      .p_valid_o      (p_valid),
      .p_ready_i      (p_ready),
      .p_accept_o     (p_accept),
      .p_chan_o       (p_chan),
      .p_rsp_o        (p_rsp),
      .p_instr_o      (p_instr),
      .p_multi_o      (p_multi),
      .accept_cnt_o   (acc_cnt),
      .reject_cnt_o   (rej_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic acc_pkg::prd_rsp_t hit_rsp(input acc_pkg::prd_rsp_t r);
      acc_pkg::prd_rsp_t t;
      t        = r;
      t.accept = 1'b1;
      return t;
   endfunction

   // Inputs driven and outputs sampled 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] w_words [8];
   logic [0:0]  e_chan  [8];
   logic        e_acc   [8];

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      ch_en   = 2'b11;
      q_data  = '0;
      q_valid = 1'b0;
      p_ready = 1'b1;

      w_words = '{32'h2B, 32'h5B, 32'h13, 32'h12B, 32'h7B, 32'h105B, 32'h2B, 32'h13};
      e_chan  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      e_acc   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      repeat (2) step();
      check_eq("rst_p_valid",  64'(p_valid),  64'd0);
      check_eq("rst_p_accept", 64'(p_accept), 64'd0);
      check_eq("rst_p_chan",   64'(p_chan),   64'd0);
      check_eq("rst_p_multi",  64'(p_multi),  64'd0);
      check_eq("rst_p_instr",  64'(p_instr),  64'd0);
      check_eq("rst_p_rsp",    64'(p_rsp),    64'(acc_pkg::PrdRspDefault));
      check_eq("rst_acc_cnt",  64'(acc_cnt),  64'd0);
      check_eq("rst_rej_cnt",  64'(rej_cnt),  64'd0);
      check_eq("rst_q_ready",  64'(q_ready),  64'd1);
      rst_n = 1'b1;
      step();

      // Hit in both channels: channel 0 entry 0 wins, multi set.
      q_valid = 1'b1; q_data = 32'h2B; ch_en = 2'b11;
      #1;
      check_eq("hit_q_ready", 64'(q_ready), 64'd1);
      step();
      q_valid = 1'b0;
      check_eq("hit_p_valid",  64'(p_valid),  64'd1);
      check_eq("hit_p_accept", 64'(p_accept), 64'd1);
      check_eq("hit_p_chan",   64'(p_chan),   64'd0);
      check_eq("hit_p_multi",  64'(p_multi),  64'd1);
      check_eq("hit_p_rsp",    64'(p_rsp),    64'(hit_rsp(RSP0)));
      check_eq("hit_p_instr",  64'(p_instr),  64'h2B);
      check_eq("hit_acc_cnt",  64'(acc_cnt),  64'd1);
      check_eq("hit_rej_cnt",  64'(rej_cnt),  64'd0);

      // Channel 0 disabled: channel 1 wins alone.
      ch_en = 2'b10; q_valid = 1'b1; q_data = 32'h2B;
      step();
      q_valid = 1'b0; ch_en = 2'b11;
      check_eq("en10_p_valid",  64'(p_valid),  64'd1);
      check_eq("en10_p_chan",   64'(p_chan),   64'd1);
      check_eq("en10_p_multi",  64'(p_multi),  64'd0);
      check_eq("en10_p_accept", 64'(p_accept), 64'd1);
      check_eq("en10_p_rsp",    64'(p_rsp),    64'(hit_rsp(RSP1)));
      check_eq("en10_acc_cnt",  64'(acc_cnt),  64'd2);

      // Miss is reported, not dropped.
      q_valid = 1'b1; q_data = 32'h13;
      step();
      q_valid = 1'b0;
      check_eq("miss_p_valid",  64'(p_valid),  64'd1);
      check_eq("miss_p_accept", 64'(p_accept), 64'd0);
      check_eq("miss_p_chan",   64'(p_chan),   64'd0);
      check_eq("miss_p_multi",  64'(p_multi),  64'd0);
      check_eq("miss_p_rsp",    64'(p_rsp),    64'(acc_pkg::PrdRspDefault));
      check_eq("miss_rej_cnt",  64'(rej_cnt),  64'd1);
      check_eq("miss_acc_cnt",  64'(acc_cnt),  64'd2);

      // Backpressure: held result stays put, request is stalled.
      p_ready = 1'b0; q_valid = 1'b1; q_data = 32'h5B;
      #1;
      check_eq("bp_q_ready_0", 64'(q_ready), 64'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("bp_q_ready",  64'(q_ready),  64'd0);
         check_eq("bp_p_valid",  64'(p_valid),  64'd1);
         check_eq("bp_p_instr",  64'(p_instr),  64'h13);
         check_eq("bp_p_accept", 64'(p_accept), 64'd0);
      end
      check_eq("bp_rej_cnt", 64'(rej_cnt), 64'd1);
      check_eq("bp_acc_cnt", 64'(acc_cnt), 64'd2);

      // Release and stream 8 words back to back.
      p_ready = 1'b1; q_data = w_words[0];
      for (int k = 0; k < 8; k++) begin
         step();
         check_eq("str_p_valid",  64'(p_valid),  64'd1);
         check_eq("str_p_instr",  64'(p_instr),  64'(w_words[k]));
         check_eq("str_p_chan",   64'(p_chan),   64'(e_chan[k]));
         check_eq("str_p_accept", 64'(p_accept), 64'(e_acc[k]));
         if (k < 7) q_data = w_words[k+1];
         else       q_valid = 1'b0;
      end
      check_eq("str_acc_cnt", 64'(acc_cnt), 64'd7);
      check_eq("str_rej_cnt", 64'(rej_cnt), 64'd4);

      // Flush with a simultaneous handshake: result dropped, not counted, data kept.
      q_valid = 1'b1; q_data = 32'h2B; flush = 1'b1;
      #1;
      check_eq("fl_q_ready", 64'(q_ready), 64'd1);
      step();
      flush = 1'b0; q_valid = 1'b0;
      check_eq("fl_p_valid", 64'(p_valid), 64'd0);
      check_eq("fl_acc_cnt", 64'(acc_cnt), 64'd7);
      check_eq("fl_rej_cnt", 64'(rej_cnt), 64'd4);
      check_eq("fl_p_instr", 64'(p_instr), 64'h13);

      // Saturation: 20 more hits on a 4-bit counter.
      q_valid = 1'b1; q_data = 32'h2B;
      repeat (20) step();
      q_valid = 1'b0;
      check_eq("sat_acc_cnt", 64'(acc_cnt), 64'd15);
      check_eq("sat_p_valid", 64'(p_valid), 64'd1);
      q_valid = 1'b1;
      step();
      q_valid = 1'b0;
      check_eq("sat_acc_hold", 64'(acc_cnt), 64'd15);
      check_eq("sat_rej_cnt",  64'(rej_cnt), 64'd4);

      // Asynchronous reset while a result is held.
      q_valid = 1'b1; q_data = 32'h5B;
      step();
      q_valid = 1'b0; p_ready = 1'b0;
      check_eq("ar_pre_valid", 64'(p_valid), 64'd1);
      check_eq("ar_pre_chan",  64'(p_chan),  64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("ar_p_valid",  64'(p_valid),  64'd0);
      check_eq("ar_acc_cnt",  64'(acc_cnt),  64'd0);
      check_eq("ar_rej_cnt",  64'(rej_cnt),  64'd0);
      check_eq("ar_p_rsp",    64'(p_rsp),    64'(acc_pkg::PrdRspDefault));
      check_eq("ar_p_accept", 64'(p_accept), 64'd0);
      check_eq("ar_p_chan",   64'(p_chan),   64'd0);
      check_eq("ar_p_instr",  64'(p_instr),  64'd0);
      step();
      rst_n = 1'b1; p_ready = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
